// File: rtl/hfrv_trace_pkg.sv
// Shared constants, types and the opcode classifier for the HF-RISCV retirement trace buffer.
package hfrv_trace_pkg;

    localparam int unsigned NUM_CLASSES  = 11;
    localparam int unsigned CLASS_W      = 4;
    localparam int unsigned TRACE_DATA_W = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] MODE_STREAM   = 2'd0;
    localparam logic [1:0] MODE_CIRCULAR = 2'd1;
    localparam logic [1:0] MODE_TRIGGER  = 2'd2;

    typedef enum logic [CLASS_W-1:0] {
        CLS_LUI    = 4'd0,
        CLS_AUIPC  = 4'd1,
        CLS_JAL    = 4'd2,
        CLS_JALR   = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_LOAD   = 4'd5,
        CLS_STORE  = 4'd6,
        CLS_OP_IMM = 4'd7,
        CLS_OP     = 4'd8,
        CLS_SYSTEM = 4'd9,
        CLS_OTHER  = 4'd10
    } trace_class_e;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        ARMED,
        POST,
        FROZEN
    } trace_state_e;

    typedef struct packed {
        logic [TRACE_DATA_W-1:0] pc;
        logic [TRACE_DATA_W-1:0] instr;
    } trace_entry_t;

    // Compressed encodings (instr[1:0] != 2'b11) never match a listed opcode, so they fall into OTHER.
    function automatic trace_class_e classify(input logic [6:0] opcode);
        trace_class_e cls;
        case (opcode)
            OPC_LUI:    cls = CLS_LUI;
            OPC_AUIPC:  cls = CLS_AUIPC;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_OP_IMM: cls = CLS_OP_IMM;
            OPC_OP:     cls = CLS_OP;
            OPC_SYSTEM: cls = CLS_SYSTEM;
            default:    cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/hfrv_trace_fifo.sv
// Trace entry storage: power-of-two ring with head/tail/level, optional overwrite-oldest when full.
module hfrv_trace_fifo #(
    parameter int unsigned ENTRY_W = 64,
    parameter int unsigned DEPTH   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     overwrite_en,
    input  logic                     pop_ready,
    output logic                     out_valid,
    output logic [ENTRY_W-1:0]       out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [LVL_W-1:0]   level_q;
    logic [LVL_W-1:0]   level_d;
    logic               empty;
    logic               full;
    logic               do_pop;
    logic               wr_en;
    logic               head_adv;
    logic               tail_adv;

    // Push/pop arbitration; a pop on an empty buffer is ignored so a simultaneous push simply lands.
    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == LVL_W'(DEPTH));
        do_pop   = pop_ready & ~empty;
        wr_en    = 1'b0;
        head_adv = do_pop;
        tail_adv = 1'b0;
        drop_c   = 1'b0;
        level_d  = level_q;
        if (push) begin
            if (full && !do_pop) begin
                drop_c = 1'b1;
                if (overwrite_en) begin
                    wr_en    = 1'b1;
                    tail_adv = 1'b1;
                    head_adv = 1'b1;
                end
            end else begin
                wr_en    = 1'b1;
                tail_adv = 1'b1;
                if (!do_pop) begin
                    level_d = level_q + LVL_W'(1);
                end
            end
        end else if (do_pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            if (head_adv) head_q <= head_q + PTR_W'(1);
            if (tail_adv) tail_q <= tail_q + PTR_W'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[tail_q] <= push_data;
        end
    end

    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : mem[head_q];
    assign level     = level_q;

endmodule

// File: rtl/hfrv_trace_buffer.sv
// Retirement-trace capture: classifies retired instructions, filters by class, buffers {pc, instr} and counts hits.
module hfrv_trace_buffer
    import hfrv_trace_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned POST_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ret_valid,
    input  logic [DATA_W-1:0]        ret_pc,
    input  logic [DATA_W-1:0]        ret_instr,
    input  logic                     cfg_enable,
    input  logic [1:0]               cfg_mode,
    input  logic [NUM_CLASSES-1:0]   cfg_class_mask,
    input  logic [DATA_W-1:0]        cfg_trig_pc,
    input  logic [POST_W-1:0]        cfg_post_count,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_pc,
    output logic [DATA_W-1:0]        out_instr,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     frozen,
    input  logic [3:0]               cnt_sel,
    output logic [CNT_W-1:0]         cnt_value
);

    localparam int unsigned ENTRY_W = 2 * DATA_W;

    trace_state_e         state_q;
    trace_state_e         state_d;
    logic [1:0]           mode_q;
    logic [1:0]           mode_d;
    logic [POST_W-1:0]    post_left_q;
    logic [POST_W-1:0]    post_left_d;
    logic [CNT_W-1:0]     class_cnt_q [NUM_CLASSES];
    logic [CNT_W-1:0]     drop_cnt_q;
    logic [CLASS_W-1:0]   cls_idx;
    logic                 capturing;
    logic                 hit;
    logic                 push;
    logic                 overwrite_en;
    logic                 fifo_drop;
    logic [ENTRY_W-1:0]   head_data;

    assign cls_idx = classify(ret_instr[6:0]);

    // Next-state and capture controls; cfg_mode is only latched on leaving IDLE.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        post_left_d  = post_left_q;
        capturing    = (state_q == RUN) || (state_q == ARMED) || (state_q == POST);
        hit          = ret_valid & cfg_class_mask[cls_idx] & capturing;
        push         = hit & ~clear;
        overwrite_en = (state_q == ARMED) || ((state_q == RUN) && (mode_q == MODE_CIRCULAR));
        if (clear || !cfg_enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    mode_d  = cfg_mode;
                    state_d = (cfg_mode == MODE_TRIGGER) ? ARMED : RUN;
                end
                RUN: begin
                    state_d = RUN;
                end
                ARMED: begin
                    if (hit && (ret_pc == cfg_trig_pc)) begin
                        post_left_d = cfg_post_count;
                        state_d     = (cfg_post_count == '0) ? FROZEN : POST;
                    end
                end
                POST: begin
                    if (hit) begin
                        post_left_d = post_left_q - POST_W'(1);
                        if (post_left_q <= POST_W'(1)) begin
                            state_d = FROZEN;
                        end
                    end
                end
                FROZEN: begin
                    state_d = FROZEN;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= MODE_STREAM;
            post_left_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            post_left_q <= post_left_d;
        end
    end

    // Saturating per-class hit counters and drop counter; clear wins over any same-cycle update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CLASSES; k++) class_cnt_q[k] <= '0;
            drop_cnt_q <= '0;
        end else if (clear) begin
            for (int k = 0; k < NUM_CLASSES; k++) class_cnt_q[k] <= '0;
            drop_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                if (hit && (cls_idx == CLASS_W'(k)) && (class_cnt_q[k] != '1)) begin
                    class_cnt_q[k] <= class_cnt_q[k] + CNT_W'(1);
                end
            end
            if (fifo_drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end
    end

    hfrv_trace_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .flush        (clear),
        .push         (push),
        .push_data    ({ret_pc, ret_instr}),
        .overwrite_en (overwrite_en),
        .pop_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (head_data),
        .level        (level),
        .drop_c       (fifo_drop)
    );

    always_comb begin
        cnt_value = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (cnt_sel == 4'(k)) cnt_value = class_cnt_q[k];
        end
    end

    assign out_pc    = head_data[ENTRY_W-1:DATA_W];
    assign out_instr = head_data[DATA_W-1:0];
    assign drop_cnt  = drop_cnt_q;
    assign frozen    = (state_q == FROZEN);

endmodule

// File: tb/tb_hfrv_trace_buffer.sv
// Self-checking bench for hfrv_trace_buffer: directed scenarios plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_hfrv_trace_buffer;
    import hfrv_trace_pkg::trace_entry_t;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned POST_W = 8;
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [31:0] I_ADDI = 32'h00100093;
    localparam logic [31:0] I_LW   = 32'h0000a103;
    localparam logic [31:0] I_JAL  = 32'h0000006f;
    localparam logic [31:0] I_ADD  = 32'h002081b3;

    localparam int P_IDLE = 0, P_RUN = 1, P_ARMED = 2, P_POST = 3, P_FROZEN = 4;

    logic              clk;
    logic              reset;
    logic              ret_valid;
    logic [DATA_W-1:0] ret_pc;
    logic [DATA_W-1:0] ret_instr;
    logic              cfg_enable;
    logic [1:0]        cfg_mode;
    logic [10:0]       cfg_class_mask;
    logic [DATA_W-1:0] cfg_trig_pc;
    logic [POST_W-1:0] cfg_post_count;
    logic              clear;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_pc;
    logic [DATA_W-1:0] out_instr;
    logic [LVL_W-1:0]  level;
    logic [CNT_W-1:0]  drop_cnt;
    logic              frozen;
    logic [3:0]        cnt_sel;
    logic [CNT_W-1:0]  cnt_value;

    hfrv_trace_buffer #(
        .DATA_W (DATA_W), .DEPTH (DEPTH), .CNT_W (CNT_W), .POST_W (POST_W)
    ) dut (
        .clk (clk), .reset (reset), .ret_valid (ret_valid), .ret_pc (ret_pc),
        .ret_instr (ret_instr), .cfg_enable (cfg_enable), .cfg_mode (cfg_mode),
        .cfg_class_mask (cfg_class_mask), .cfg_trig_pc (cfg_trig_pc),
        .cfg_post_count (cfg_post_count), .clear (clear), .out_valid (out_valid),
        .out_ready (out_ready), .out_pc (out_pc), .out_instr (out_instr),
        .level (level), .drop_cnt (drop_cnt), .frozen (frozen),
        .cnt_sel (cnt_sel), .cnt_value (cnt_value)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of entries plus scalar bookkeeping.
    trace_entry_t mq[$];
    int unsigned  m_cnt [11];
    int unsigned  m_drop;
    int           m_phase;
    int           m_mode;
    int unsigned  m_post_left;

    function automatic int class_of(input logic [31:0] ins);
        case (ins[6:0])
            7'h37: return 0;
            7'h17: return 1;
            7'h6f: return 2;
            7'h67: return 3;
            7'h63: return 4;
            7'h03: return 5;
            7'h23: return 6;
            7'h13: return 7;
            7'h33: return 8;
            7'h73: return 9;
            default: return 10;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        foreach (m_cnt[k]) m_cnt[k] = 0;
        m_drop = 0;
        m_phase = P_IDLE;
        m_mode = 0;
        m_post_left = 0;
    endtask

    task automatic model_step();
        bit popping, hit, cap;
        int c;
        trace_entry_t e;
        if (clear) begin
            model_reset();
            return;
        end
        cap = (m_phase == P_RUN) || (m_phase == P_ARMED) || (m_phase == P_POST);
        c = class_of(ret_instr);
        hit = ret_valid && cfg_class_mask[c] && cap;
        popping = out_ready && (mq.size() > 0);
        if (hit) begin
            e.pc = ret_pc;
            e.instr = ret_instr;
            if (mq.size() == DEPTH && !popping) begin
                if (m_drop < CNT_MAX) m_drop++;
                if (m_phase == P_ARMED || (m_phase == P_RUN && m_mode == 1)) begin
                    void'(mq.pop_front());
                    mq.push_back(e);
                end
            end else begin
                mq.push_back(e);
            end
            if (m_cnt[c] < CNT_MAX) m_cnt[c]++;
        end
        if (popping) void'(mq.pop_front());
        if (!cfg_enable) begin
            m_phase = P_IDLE;
        end else if (m_phase == P_IDLE) begin
            m_mode = int'(cfg_mode);
            m_phase = (cfg_mode == 2'd2) ? P_ARMED : P_RUN;
        end else if (m_phase == P_ARMED && hit && ret_pc == cfg_trig_pc) begin
            m_post_left = cfg_post_count;
            m_phase = (cfg_post_count == 0) ? P_FROZEN : P_POST;
        end else if (m_phase == P_POST && hit) begin
            m_post_left--;
            if (m_post_left == 0) m_phase = P_FROZEN;
        end
    endtask

    task automatic cycle(input bit v, input logic [31:0] pc, input logic [31:0] ins, input bit rdy);
        ret_valid = v;
        ret_pc = pc;
        ret_instr = ins;
        out_ready = rdy;
        model_step();
        @(posedge clk);
        #1;
        ret_valid = 1'b0;
        out_ready = 1'b0;
        clear = 1'b0;
    endtask

    task automatic read_cnt(input int sel, output logic [CNT_W-1:0] val);
        cnt_sel = 4'(sel);
        #1;
        val = cnt_value;
    endtask

    task automatic setup(input logic [1:0] mode, input logic [10:0] mask,
                         input logic [31:0] trig, input logic [7:0] post);
        cfg_enable = 1'b0;
        clear = 1'b1;
        cycle(0, 0, 0, 0);
        cfg_mode = mode;
        cfg_class_mask = mask;
        cfg_trig_pc = trig;
        cfg_post_count = post;
        cfg_enable = 1'b1;
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        logic [CNT_W-1:0] v;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
        checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL reset_frozen got %0b exp 0", frozen); end
        checks++; if (out_pc !== '0 || out_instr !== '0) begin errors++; $display("FAIL reset_out_data got %h/%h exp 0/0", out_pc, out_instr); end
        read_cnt(7, v);
        checks++; if (v !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", v); end
    endtask

    task automatic test_stream_basic();
        logic [31:0] pcs [3];
        logic [31:0] ins [3];
        logic [CNT_W-1:0] v;
        pcs = '{32'h1000, 32'h1004, 32'h1008};
        ins = '{I_ADDI, I_LW, I_JAL};
        setup(2'd0, 11'h7FF, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, pcs[i], ins[i], 0);
        checks++; if (level !== LVL_W'(3)) begin errors++; $display("FAIL basic_level got %0d exp 3", level); end
        read_cnt(7, v);
        checks++; if (v !== CNT_W'(1)) begin errors++; $display("FAIL basic_cnt_opimm got %0d exp 1", v); end
        read_cnt(5, v);
        checks++; if (v !== CNT_W'(1)) begin errors++; $display("FAIL basic_cnt_load got %0d exp 1", v); end
        read_cnt(2, v);
        checks++; if (v !== CNT_W'(1)) begin errors++; $display("FAIL basic_cnt_jal got %0d exp 1", v); end
        read_cnt(8, v);
        checks++; if (v !== '0) begin errors++; $display("FAIL basic_cnt_op got %0d exp 0", v); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_pc !== pcs[i] || out_instr !== ins[i]) begin
                errors++; $display("FAIL basic_order[%0d] got %h/%h exp %h/%h", i, out_pc, out_instr, pcs[i], ins[i]);
            end
            cycle(0, 0, 0, 1);
        end
        checks++; if (out_valid !== 1'b0 || out_pc !== '0) begin errors++; $display("FAIL basic_empty got v=%0b pc=%h exp v=0 pc=0", out_valid, out_pc); end
    endtask

    task automatic test_full(input logic [1:0] mode, input logic [31:0] first_pc, input string tag);
        setup(mode, 11'h7FF, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, 32'(i * 4), I_ADDI, 0);
        checks++; if (level !== LVL_W'(DEPTH)) begin errors++; $display("FAIL %s_level got %0d exp %0d", tag, level, DEPTH); end
        checks++; if (drop_cnt !== CNT_W'(4)) begin errors++; $display("FAIL %s_drop got %0d exp 4", tag, drop_cnt); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== first_pc + 32'(i * 4)) begin
                errors++; $display("FAIL %s_drain[%0d] got v=%0b pc=%h exp pc=%h", tag, i, out_valid, out_pc, first_pc + 32'(i * 4));
            end
            cycle(0, 0, 0, 1);
        end
        checks++; if (level !== '0) begin errors++; $display("FAIL %s_drained_level got %0d exp 0", tag, level); end
    endtask

    task automatic test_trigger();
        logic [CNT_W-1:0] v;
        setup(2'd2, 11'h7FF, 32'h100, 8'd3);
        for (int pc = 32'hF0; pc <= 32'h130; pc += 4) cycle(1, 32'(pc), I_ADDI, 0);
        checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL trig_frozen got %0b exp 1", frozen); end
        checks++; if (level !== LVL_W'(8)) begin errors++; $display("FAIL trig_level got %0d exp 8", level); end
        read_cnt(7, v);
        checks++; if (v !== CNT_W'(8)) begin errors++; $display("FAIL trig_cnt got %0d exp 8", v); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_pc !== 32'hF0 + 32'(i * 4)) begin
                errors++; $display("FAIL trig_entry[%0d] got %h exp %h", i, out_pc, 32'hF0 + 32'(i * 4));
            end
            cycle(0, 0, 0, 1);
        end
        cycle(1, 32'h100, I_ADDI, 0);
        cycle(1, 32'h104, I_LW, 0);
        read_cnt(7, v);
        checks++; if (v !== CNT_W'(8) || level !== '0) begin errors++; $display("FAIL trig_after_frozen got cnt=%0d lvl=%0d exp 8/0", v, level); end
    endtask

    task automatic test_mask_clear();
        logic [31:0] seq [10];
        logic [CNT_W-1:0] v;
        seq = '{I_LW, I_ADDI, I_ADD, I_LW, I_ADDI, I_ADDI, I_LW, I_ADD, I_ADDI, I_LW};
        setup(2'd0, 11'h020, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 32'h200 + 32'(i * 4), seq[i], 0);
        checks++; if (level !== LVL_W'(4)) begin errors++; $display("FAIL mask_level got %0d exp 4", level); end
        read_cnt(5, v);
        checks++; if (v !== CNT_W'(4)) begin errors++; $display("FAIL mask_cnt_load got %0d exp 4", v); end
        read_cnt(7, v);
        checks++; if (v !== '0) begin errors++; $display("FAIL mask_cnt_opimm got %0d exp 0", v); end
        read_cnt(8, v);
        checks++; if (v !== '0) begin errors++; $display("FAIL mask_cnt_op got %0d exp 0", v); end
        clear = 1'b1;
        cycle(1, 32'h300, I_LW, 1);
        checks++; if (level !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL clear_level got %0d v=%0b exp 0", level, out_valid); end
        for (int k = 0; k < 11; k++) begin
            read_cnt(k, v);
            checks++; if (v !== '0) begin errors++; $display("FAIL clear_cnt[%0d] got %0d exp 0", k, v); end
        end
    endtask

    task automatic test_random();
        logic [6:0] opcs [11];
        logic [31:0] ins;
        logic [CNT_W-1:0] v;
        int sel;
        logic [31:0] exp_pc, exp_ins;
        opcs = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0b};
        setup(2'd1, 11'h7FF, 32'h120, 8'd2);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) clear = 1'b1;
            if ($urandom_range(0, 99) == 0) cfg_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 119) == 0) begin
                cfg_enable = ~cfg_enable;
                cfg_class_mask = 11'($urandom) | 11'($urandom);
                cfg_trig_pc = 32'h100 + 32'($urandom_range(0, 31) * 4);
                cfg_post_count = 8'($urandom_range(0, 5));
            end
            ins = {$urandom} & 32'hFFFF_FF80;
            ins[6:0] = ($urandom_range(0, 9) == 0) ? 7'($urandom) : opcs[$urandom_range(0, 10)];
            cycle($urandom_range(0, 3) != 0, 32'h100 + 32'($urandom_range(0, 31) * 4), ins,
                  $urandom_range(0, 2) == 0);
            exp_pc = (mq.size() > 0) ? mq[0].pc : 32'h0;
            exp_ins = (mq.size() > 0) ? mq[0].instr : 32'h0;
            checks++; if (level !== LVL_W'(mq.size()) || out_valid !== (mq.size() > 0)) begin
                errors++; $display("FAIL rnd_level[%0d] got %0d/%0b exp %0d", n, level, out_valid, mq.size()); end
            checks++; if (out_pc !== exp_pc || out_instr !== exp_ins) begin
                errors++; $display("FAIL rnd_head[%0d] got %h/%h exp %h/%h", n, out_pc, out_instr, exp_pc, exp_ins); end
            checks++; if (drop_cnt !== CNT_W'(m_drop) || frozen !== (m_phase == P_FROZEN)) begin
                errors++; $display("FAIL rnd_drop_frozen[%0d] got %0d/%0b exp %0d/%0b", n, drop_cnt, frozen, m_drop, m_phase == P_FROZEN); end
            sel = $urandom_range(0, 15);
            read_cnt(sel, v);
            checks++; if (v !== ((sel < 11) ? CNT_W'(m_cnt[sel]) : '0)) begin
                errors++; $display("FAIL rnd_cnt[%0d] sel=%0d got %0d exp %0d", n, sel, v, (sel < 11) ? m_cnt[sel] : 0); end
        end
    endtask

    task automatic test_async_reset();
        setup(2'd2, 11'h7FF, 32'h14, 8'd0);
        for (int i = 0; i < 6; i++) cycle(1, 32'(i * 4), I_ADDI, 0);
        cycle(0, 0, 0, 1);
        checks++; if (level !== LVL_W'(5) || frozen !== 1'b1) begin errors++; $display("FAIL arst_pre got lvl=%0d fz=%0b exp 5/1", level, frozen); end
        out_ready = 1'b1;
        #4;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || level !== '0) begin errors++; $display("FAIL arst_immediate got v=%0b lvl=%0d exp 0/0", out_valid, level); end
        checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL arst_frozen got %0b exp 0", frozen); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1;
        ret_valid = 1'b0; ret_pc = '0; ret_instr = '0;
        cfg_enable = 1'b0; cfg_mode = 2'd0; cfg_class_mask = '0;
        cfg_trig_pc = '0; cfg_post_count = '0; clear = 1'b0;
        out_ready = 1'b0; cnt_sel = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_stream_basic();
        test_full(2'd0, 32'h0, "stream");
        test_full(2'd1, 32'h10, "circular");
        test_trigger();
        test_mask_clear();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
